disp_scheduler: RTL and testbench

//  Display controller in front of the 7-segment OTP/status display path. Chooses what the two
//  2-digit displays show: blank, generated OTP, user entry, status message or persistent lock.

---
 rtl/disp_scheduler.sv | 259 +++++++++++++++++++++++++
 tb/tb_disp_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/disp_scheduler.sv
// Display scheduler for the two 2-digit 7-segment displays.
// Picks the displayed word (blank / OTP / user entry / status message / lock),
// arbitrates status events by priority, times messages and user idle, and
// time-multiplexes the 4 nibbles onto bcd1/bcd2/an with registered outputs.
module disp_scheduler #(
   parameter int SCAN_DIV  = 50000,
   parameter int MSG_CYC   = 2000000,
   parameter int USER_IDLE = 8000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        otp_vld,
   input  logic        key_evt,
   input  logic        unlock,
   input  logic        lock,
   input  logic        expire,
   input  logic [1:0]  wrng_att,
   input  logic [15:0] lfsr_otp,
   input  logic [15:0] user_otp,
   output logic [3:0]  bcd1,
   output logic [3:0]  bcd2,
   output logic [1:0]  an,
   output logic        shft,
   output logic [2:0]  mode
);

   localparam int SCAN_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int MSG_W  = (MSG_CYC   > 1) ? $clog2(MSG_CYC)   : 1;
   localparam int IDLE_W = (USER_IDLE > 1) ? $clog2(USER_IDLE) : 1;

   localparam logic [15:0] W_BLANK = 16'hFFFF;
   localparam logic [15:0] W_LOCK  = 16'h405A;
   localparam logic [15:0] W_OPEN  = 16'h0768;
   localparam logic [15:0] W_EXP   = 16'h67FF;

   typedef enum logic [2:0] {
      ST_BLANK  = 3'd0,
      ST_OTP    = 3'd1,
      ST_USER   = 3'd2,
      ST_MSG    = 3'd3,
      ST_LOCKED = 3'd4
   } state_t;

   // Input sampling stage and previous-value copies for edge detection
   logic        otp_vld_q, key_q, unlock_q, lock_q, expire_q;
   logic [1:0]  wrng_q;
   logic [15:0] lfsr_q, user_q;
   logic        unlock_p_q, lock_p_q, expire_p_q;
   logic [1:0]  wrng_p_q;

   // Scheduler state
   state_t      state_q, state_d;
   logic [15:0] otp_reg_q, otp_reg_d;
   logic        have_q, have_d;
   logic [15:0] msg_reg_q, msg_reg_d;
   logic [1:0]  msg_prio_q, msg_prio_d;
   logic [MSG_W-1:0]  msg_tmr_q, msg_tmr_d;
   logic [IDLE_W-1:0] idle_q, idle_d;

   // Scan and output registers
   logic [SCAN_W-1:0] scan_q;
   logic              slot_q;
   logic [3:0]        bcd1_q, bcd2_q;
   logic [1:0]        an_q;
   logic              shft_q;

   // Event detection / arbitration
   logic        exp_ev, lock_ev, unl_ev, wrg_ev;
   logic        ev_vld;
   logic [1:0]  ev_prio;
   logic [15:0] ev_word;

   // Output word selection
   logic [15:0] word_c;
   logic        shft_c;

   // Register the raw inputs; previous copies reset to 0 so a level already
   // high after reset release is seen as a rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         otp_vld_q  <= 1'b0;
         key_q      <= 1'b0;
         unlock_q   <= 1'b0;
         lock_q     <= 1'b0;
         expire_q   <= 1'b0;
         wrng_q     <= 2'd0;
         lfsr_q     <= 16'd0;
         user_q     <= 16'd0;
         unlock_p_q <= 1'b0;
         lock_p_q   <= 1'b0;
         expire_p_q <= 1'b0;
         wrng_p_q   <= 2'd0;
      end else begin
         otp_vld_q  <= otp_vld;
         key_q      <= key_evt;
         unlock_q   <= unlock;
         lock_q     <= lock;
         expire_q   <= expire;
         wrng_q     <= wrng_att;
         lfsr_q     <= lfsr_otp;
         user_q     <= user_otp;
         unlock_p_q <= unlock_q;
         lock_p_q   <= lock_q;
         expire_p_q <= expire_q;
         wrng_p_q   <= wrng_q;
      end
   end

   // Edge detection and fixed-priority pick: expire > lock > unlock > wrong
   always_comb begin
      exp_ev  = expire_q & ~expire_p_q;
      lock_ev = lock_q & ~lock_p_q;
      unl_ev  = unlock_q & ~unlock_p_q;
      wrg_ev  = (wrng_q != wrng_p_q) && (wrng_q != 2'd0);
      ev_vld  = 1'b1;
      ev_prio = 2'd0;
      ev_word = W_BLANK;
      if (exp_ev) begin
         ev_prio = 2'd3;
         ev_word = W_EXP;
      end else if (lock_ev) begin
         ev_prio = 2'd2;
         ev_word = W_LOCK;
      end else if (unl_ev) begin
         ev_prio = 2'd1;
         ev_word = W_OPEN;
      end else if (wrg_ev) begin
         ev_prio = 2'd0;
         ev_word = {12'h699, 2'b00, wrng_q};
      end else begin
         ev_vld  = 1'b0;
      end
   end

   // State register plus the timers and latched words that travel with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_BLANK;
         otp_reg_q  <= 16'd0;
         have_q     <= 1'b0;
         msg_reg_q  <= W_BLANK;
         msg_prio_q <= 2'd0;
         msg_tmr_q  <= '0;
         idle_q     <= '0;
      end else begin
         state_q    <= state_d;
         otp_reg_q  <= otp_reg_d;
         have_q     <= have_d;
         msg_reg_q  <= msg_reg_d;
         msg_prio_q <= msg_prio_d;
         msg_tmr_q  <= msg_tmr_d;
         idle_q     <= idle_d;
      end
   end

   // Next-state logic; a status event always wins the state change, while an
   // OTP arriving in the same cycle is still latched.
   always_comb begin
      state_d    = state_q;
      msg_reg_d  = msg_reg_q;
      msg_prio_d = msg_prio_q;
      msg_tmr_d  = msg_tmr_q;
      idle_d     = '0;
      otp_reg_d  = otp_vld_q ? lfsr_q : otp_reg_q;
      have_d     = exp_ev ? 1'b0 : (otp_vld_q ? 1'b1 : have_q);
      case (state_q)
         ST_BLANK, ST_OTP, ST_USER: begin
            if (ev_vld) begin
               state_d    = ST_MSG;
               msg_reg_d  = ev_word;
               msg_prio_d = ev_prio;
               msg_tmr_d  = '0;
            end else if (otp_vld_q) begin
               state_d = ST_OTP;
            end else if (key_q) begin
               state_d = ST_USER;
            end else if (state_q == ST_USER) begin
               if (idle_q == IDLE_W'(USER_IDLE - 1))
                  state_d = have_d ? ST_OTP : ST_BLANK;
               else
                  idle_d = idle_q + IDLE_W'(1);
            end
         end
         ST_MSG: begin
            if (ev_vld && (ev_prio >= msg_prio_q)) begin
               msg_reg_d  = ev_word;
               msg_prio_d = ev_prio;
               msg_tmr_d  = '0;
            end else if (msg_tmr_q == MSG_W'(MSG_CYC - 1)) begin
               if (lock_q)
                  state_d = ST_LOCKED;
               else
                  state_d = have_d ? ST_OTP : ST_BLANK;
            end else begin
               msg_tmr_d = msg_tmr_q + MSG_W'(1);
            end
         end
         ST_LOCKED: begin
            if (ev_vld) begin
               state_d    = ST_MSG;
               msg_reg_d  = ev_word;
               msg_prio_d = ev_prio;
               msg_tmr_d  = '0;
            end else if (!lock_q) begin
               state_d = have_d ? ST_OTP : ST_BLANK;
            end
         end
         default: state_d = ST_BLANK;
      endcase
   end

   // Output decode: displayed word and char/hex mode for the current state
   always_comb begin
      word_c = W_BLANK;
      shft_c = 1'b1;
      case (state_q)
         ST_OTP:    begin word_c = otp_reg_q; shft_c = 1'b0; end
         ST_USER:   begin word_c = user_q;    shft_c = 1'b0; end
         ST_MSG:    begin word_c = msg_reg_q; shft_c = 1'b1; end
         ST_LOCKED: begin word_c = W_LOCK;    shft_c = 1'b1; end
         default:   begin word_c = W_BLANK;   shft_c = 1'b1; end
      endcase
   end

   // Free-running scan counter; slot toggles on each wrap, independent of state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_q <= '0;
         slot_q <= 1'b0;
      end else if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
         scan_q <= '0;
         slot_q <= ~slot_q;
      end else begin
         scan_q <= scan_q + SCAN_W'(1);
      end
   end

   // All display outputs registered together so they never show a mixed pair
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_q   <= 2'b10;
         bcd1_q <= 4'hF;
         bcd2_q <= 4'hF;
         shft_q <= 1'b1;
      end else begin
         an_q   <= slot_q ? 2'b01 : 2'b10;
         bcd1_q <= slot_q ? word_c[11:8] : word_c[15:12];
         bcd2_q <= slot_q ? word_c[3:0]  : word_c[7:4];
         shft_q <= shft_c;
      end
   end

   assign an   = an_q;
   assign bcd1 = bcd1_q;
   assign bcd2 = bcd2_q;
   assign shft = shft_q;
   assign mode = state_q;

endmodule

// File: tb/tb_disp_scheduler.sv
// Directed bench for disp_scheduler with a small expected-word scoreboard.
module tb_disp_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        otp_vld, key_evt, unlock, lock, expire;
   logic [1:0]  wrng_att;
   logic [15:0] lfsr_otp, user_otp;
   logic [3:0]  bcd1, bcd2;
   logic [1:0]  an;
   logic        shft;
   logic [2:0]  mode;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   typedef struct {
      string       tag;
      logic [15:0] word;
      logic        shft;
      logic [2:0]  mode;
   } exp_t;

   exp_t sb[$];

   disp_scheduler #(.SCAN_DIV(4), .MSG_CYC(20), .USER_IDLE(50)) dut (
      .clk(clk), .rst(rst), .otp_vld(otp_vld), .key_evt(key_evt),
      .unlock(unlock), .lock(lock), .expire(expire), .wrng_att(wrng_att),
      .lfsr_otp(lfsr_otp), .user_otp(user_otp),
      .bcd1(bcd1), .bcd2(bcd2), .an(an), .shft(shft), .mode(mode)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic push_exp(input string tag, input logic [15:0] w, input logic s, input logic [2:0] m);
      exp_t e;
      e.tag = tag; e.word = w; e.shft = s; e.mode = m;
      sb.push_back(e);
   endtask

   // Pop the next expectation and assemble the displayed word over both slots
   task automatic check_next();
      exp_t e;
      logic [15:0] w;
      logic s0, s1;
      logic [2:0] m;
      bit ok0, ok1;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      w = 16'h0000; ok0 = 0; ok1 = 0;
      for (int i = 0; i < 20 && !ok0; i++) begin
         @(negedge clk);
         if (an === 2'b10) ok0 = 1;
      end
      w[15:12] = bcd1; w[7:4] = bcd2; s0 = shft; m = mode;
      for (int i = 0; i < 20 && !ok1; i++) begin
         @(negedge clk);
         if (an === 2'b01) ok1 = 1;
      end
      w[11:8] = bcd1; w[3:0] = bcd2; s1 = shft;
      chk({e.tag, "_scan"}, {30'd0, ok0, ok1}, 32'd3);
      chk({e.tag, "_word"}, {16'd0, w}, {16'd0, e.word});
      chk({e.tag, "_shft"}, {30'd0, s0, s1}, {30'd0, e.shft, e.shft});
      chk({e.tag, "_mode"}, {29'd0, m}, {29'd0, e.mode});
   endtask

   initial begin
      int t0;
      logic [1:0] a0;
      bit seen;
      rst = 1'b1; otp_vld = 0; key_evt = 0; unlock = 0; lock = 0; expire = 0;
      wrng_att = 2'd0; lfsr_otp = 16'h0000; user_otp = 16'h0000;
      repeat (3) @(negedge clk);
      chk("rst_an",   {30'd0, an}, 32'h2);
      chk("rst_bcd",  {24'd0, bcd1, bcd2}, 32'hFF);
      chk("rst_shft", {31'd0, shft}, 32'h1);
      chk("rst_mode", {29'd0, mode}, 32'h0);
      rst = 1'b0;

      // Idle blank display and scan cadence
      repeat (20) @(negedge clk);
      a0 = an; seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (an !== a0) seen = 1;
      end
      a0 = an;
      chk("scan_toggle_seen", {31'd0, seen}, 32'd1);
      repeat (3) @(negedge clk);
      chk("scan_hold", {30'd0, an}, {30'd0, a0});
      @(negedge clk);
      chk("scan_flip", {30'd0, an}, {30'd0, ~a0});
      push_exp("blank", 16'hFFFF, 1'b1, 3'd0);
      check_next();

      // New OTP
      lfsr_otp = 16'h1A2B; otp_vld = 1; @(negedge clk); otp_vld = 0; lfsr_otp = 16'h5555;
      push_exp("otp", 16'h1A2B, 1'b0, 3'd1);
      repeat (2) @(negedge clk);
      check_next();

      // User entry then idle timeout back to OTP
      user_otp = 16'h0304; key_evt = 1; t0 = cyc; @(negedge clk); key_evt = 0;
      push_exp("user", 16'h0304, 1'b0, 3'd2);
      push_exp("user_hold", 16'h0304, 1'b0, 3'd2);
      push_exp("user_timeout", 16'h1A2B, 1'b0, 3'd1);
      wait_until(t0 + 3);  check_next();
      wait_until(t0 + 30); check_next();
      wait_until(t0 + 62); check_next();

      // Wrong attempt message
      wrng_att = 2'd2; t0 = cyc;
      push_exp("err", 16'h6992, 1'b1, 3'd3);
      push_exp("err_done", 16'h1A2B, 1'b0, 3'd1);
      wait_until(t0 + 3);  check_next();
      wait_until(t0 + 28); check_next();

      // Lock and unlock rising together: lock wins, then LOCKED
      lock = 1; unlock = 1; t0 = cyc;
      push_exp("lockmsg", 16'h405A, 1'b1, 3'd3);
      push_exp("locked", 16'h405A, 1'b1, 3'd4);
      wait_until(t0 + 3);  check_next();
      wait_until(t0 + 28); check_next();
      key_evt = 1; @(negedge clk); key_evt = 0;
      push_exp("locked_key", 16'h405A, 1'b1, 3'd4);
      repeat (4) @(negedge clk);
      check_next();
      unlock = 0; repeat (3) @(negedge clk);
      unlock = 1; t0 = cyc;
      push_exp("open", 16'h0768, 1'b1, 3'd3);
      push_exp("relock", 16'h405A, 1'b1, 3'd4);
      wait_until(t0 + 3);  check_next();
      wait_until(t0 + 28); check_next();
      lock = 0; unlock = 0;
      push_exp("unlocked", 16'h1A2B, 1'b0, 3'd1);
      repeat (4) @(negedge clk);
      check_next();

      // Expire preempts ERR, restarts timer, clears have_otp
      wrng_att = 2'd1;
      repeat (10) @(negedge clk);
      expire = 1; t0 = cyc;
      push_exp("exp", 16'h67FF, 1'b1, 3'd3);
      push_exp("exp_done", 16'hFFFF, 1'b1, 3'd0);
      wait_until(t0 + 3);  check_next();
      wait_until(t0 + 15);
      chk("exp_restart_mode", {29'd0, mode}, 32'd3);
      wait_until(t0 + 27); check_next();

      // Async reset mid-message, then levels already high look like edges
      wrng_att = 2'd3;
      repeat (5) @(negedge clk);
      chk("pre_rst_mode", {29'd0, mode}, 32'd3);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_an",   {30'd0, an}, 32'h2);
      chk("mid_rst_bcd",  {24'd0, bcd1, bcd2}, 32'hFF);
      chk("mid_rst_shft", {31'd0, shft}, 32'h1);
      chk("mid_rst_mode", {29'd0, mode}, 32'h0);
      @(negedge clk); rst = 1'b0; t0 = cyc;
      push_exp("post_rst_exp", 16'h67FF, 1'b1, 3'd3);
      push_exp("post_rst_blank", 16'hFFFF, 1'b1, 3'd0);
      wait_until(t0 + 3);  check_next();
      wait_until(t0 + 28); check_next();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
